// File: rtl/checkswap_arbiter.sv
// Round-robin arbiter sharing one checkswap evaluator between N_REQ swap engines.
// Optional evaluator watchdog enabled by defining ARB_TIMEOUT_EN.
module checkswap_arbiter #(
  parameter int N_REQ       = 4,
  parameter int COORD_W     = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [N_REQ-1:0]           i_req,
  input  logic [N_REQ*12*COORD_W-1:0] i_req_pts,
  output logic [N_REQ-1:0]           o_gnt,
  output logic [12*COORD_W-1:0]      o_chk_pts,
  output logic                       o_chk_start,
  input  logic                       i_chk_res,
  input  logic                       i_chk_done,
  output logic [N_REQ-1:0]           o_resp_valid,
  output logic                       o_resp_swap,
  output logic                       o_resp_err,
  output logic [31:0]                o_eval_cnt,
  output logic [31:0]                o_swap_cnt
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int PTS_W = 12 * COORD_W;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_winner;
  logic [IDX_W-1:0] w_pick;
  logic             w_pick_vld;
  logic             w_timeout;

  // First requester at or above r_ptr, wrapping modulo N_REQ.
  always_comb begin : pick_proc
    int idx;
    idx        = 0;
    w_pick     = '0;
    w_pick_vld = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(r_ptr) + i;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end else begin
        idx = idx;
      end
      if (!w_pick_vld && i_req[IDX_W'(idx)]) begin
        w_pick     = IDX_W'(idx);
        w_pick_vld = 1'b1;
      end else begin
        w_pick     = w_pick;
        w_pick_vld = w_pick_vld;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] r_wdog;

  // Watchdog counts WAIT cycles; cleared while the evaluator is being launched.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_wdog <= '0;
    end else if (r_state == S_LAUNCH) begin
      r_wdog <= '0;
    end else if (r_state == S_WAIT && !w_timeout) begin
      r_wdog <= r_wdog + 1'b1;
    end else begin
      r_wdog <= r_wdog;
    end
  end

  assign w_timeout = (r_state == S_WAIT) && (r_wdog == WD_W'(TIMEOUT_CYC));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_pick_vld) begin
          w_state_nxt = S_LAUNCH;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LAUNCH: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (i_chk_done || w_timeout) begin
          w_state_nxt = S_RESP;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Grant, evaluator launch, response pulses and host counters.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_gnt        <= '0;
      o_chk_pts    <= '0;
      o_chk_start  <= 1'b0;
      o_resp_valid <= '0;
      o_resp_swap  <= 1'b0;
      o_resp_err   <= 1'b0;
      o_eval_cnt   <= 32'd0;
      o_swap_cnt   <= 32'd0;
      r_ptr        <= '0;
      r_winner     <= '0;
    end else begin
      o_chk_start  <= 1'b0;
      o_resp_valid <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_pick_vld) begin
            o_gnt       <= {{(N_REQ-1){1'b0}}, 1'b1} << w_pick;
            o_chk_pts   <= i_req_pts[int'(w_pick)*PTS_W +: PTS_W];
            r_winner    <= w_pick;
            o_chk_start <= 1'b1;
          end
        end
        S_WAIT: begin
          if (i_chk_done) begin
            o_resp_valid <= o_gnt;
            o_resp_swap  <= i_chk_res;
            o_resp_err   <= 1'b0;
            o_eval_cnt   <= o_eval_cnt + 32'd1;
            o_swap_cnt   <= o_swap_cnt + {31'd0, i_chk_res};
          end else if (w_timeout) begin
            o_resp_valid <= o_gnt;
            o_resp_swap  <= 1'b0;
            o_resp_err   <= 1'b1;
          end
        end
        S_RESP: begin
          o_gnt       <= '0;
          o_resp_swap <= 1'b0;
          o_resp_err  <= 1'b0;
          r_ptr       <= (r_winner == IDX_W'(N_REQ - 1)) ? '0 : r_winner + 1'b1;
        end
        default: begin
          o_gnt <= o_gnt;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_checkswap_arbiter.sv
// Self-checking bench for checkswap_arbiter: directed scenarios plus randomized
// traffic against a round-robin reference model.
module tb_checkswap_arbiter;
  localparam int N  = 4;
  localparam int CW = 32;
  localparam int PW = 12 * CW;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    i_req;
  logic [N*PW-1:0] i_req_pts;
  logic [N-1:0]    o_gnt;
  logic [PW-1:0]   o_chk_pts;
  logic            o_chk_start;
  logic            i_chk_res;
  logic            i_chk_done;
  logic [N-1:0]    o_resp_valid;
  logic            o_resp_swap;
  logic            o_resp_err;
  logic [31:0]     o_eval_cnt;
  logic [31:0]     o_swap_cnt;

  int checks = 0;
  int errors = 0;

  int          m_ptr;
  int unsigned m_eval;
  int unsigned m_swap;
  logic [CW-1:0] pts [N][12];

  // transaction observations
  logic [N-1:0]  obs_gnt;
  logic [PW-1:0] obs_pts;
  logic          obs_start_ok;
  int            obs_resp_c;
  logic [N-1:0]  obs_rv;
  logic          obs_swap;
  logic          obs_err;

  checkswap_arbiter #(.N_REQ(N), .COORD_W(CW), .TIMEOUT_CYC(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(i_req), .i_req_pts(i_req_pts),
    .o_gnt(o_gnt), .o_chk_pts(o_chk_pts), .o_chk_start(o_chk_start),
    .i_chk_res(i_chk_res), .i_chk_done(i_chk_done),
    .o_resp_valid(o_resp_valid), .o_resp_swap(o_resp_swap), .o_resp_err(o_resp_err),
    .o_eval_cnt(o_eval_cnt), .o_swap_cnt(o_swap_cnt)
  );

  always #5 clk = ~clk;

  task automatic pack_pts();
    for (int e = 0; e < N; e++)
      for (int k = 0; k < 12; k++)
        i_req_pts[(e*12+k)*CW +: CW] = pts[e][k];
  endtask

  function automatic logic [PW-1:0] slice_of(input int e);
    logic [PW-1:0] r;
    for (int k = 0; k < 12; k++) r[k*CW +: CW] = pts[e][k];
    return r;
  endfunction

  function automatic int model_pick(input logic [N-1:0] req);
    for (int i = 0; i < N; i++)
      if (req[(m_ptr + i) % N]) return (m_ptr + i) % N;
    return -1;
  endfunction

  task automatic apply_reset();
    rst = 1'b0; i_req = '0; i_chk_done = 1'b0; i_chk_res = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    m_ptr = 0; m_eval = 0; m_swap = 0;
  endtask

  // Current cycle is IDLE (cycle 0) with i_req already driven. Evaluator done is
  // first raised in cycle 1+dly (dly=0 -> never unless early).
  task automatic do_txn(input int dly, input logic res, input bit early,
                        input int drop_c, input logic [N-1:0] drop_mask, input int limit);
    obs_start_ok = 1'b1; obs_resp_c = -1; obs_gnt = '0; obs_pts = '0;
    obs_rv = '0; obs_swap = 1'b0; obs_err = 1'b0;
    if (early) begin i_chk_done = 1'b1; i_chk_res = res; end
    for (int c = 1; c <= limit; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin obs_gnt = o_gnt; obs_pts = o_chk_pts; end
      if (o_chk_start !== (c == 1)) obs_start_ok = 1'b0;
      if (c == drop_c) i_req = i_req & ~drop_mask;
      if (o_resp_valid !== '0) begin
        obs_resp_c = c; obs_rv = o_resp_valid; obs_swap = o_resp_swap; obs_err = o_resp_err;
        i_req = i_req & ~o_resp_valid;
        break;
      end
      if (dly > 0 && c == 1 + dly) begin i_chk_done = 1'b1; i_chk_res = res; end
    end
    i_chk_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; i_req = 4'hF; i_chk_done = 1'b1; i_chk_res = 1'b1;
    for (int k = 0; k < N; k++) for (int j = 0; j < 12; j++) pts[k][j] = $urandom;
    pack_pts();
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({o_gnt, o_chk_pts, o_chk_start, o_resp_valid, o_resp_swap, o_resp_err, o_eval_cnt, o_swap_cnt} !== '0) begin
        errors++; $display("FAIL reset_outputs gnt=%h start=%b rv=%h eval=%0d swap=%0d exp all zero",
                           o_gnt, o_chk_start, o_resp_valid, o_eval_cnt, o_swap_cnt);
      end
    end
    apply_reset();
  endtask

  task automatic test_single();
    apply_reset();
    for (int k = 0; k < 12; k++) pts[2][k] = CW'(k + 1);
    pack_pts();
    i_req = 4'b0100;
    do_txn(5, 1'b1, 1'b0, -1, '0, 40);
    checks++; if (obs_gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt got %b exp 0100", obs_gnt); end
    checks++; if (obs_pts !== slice_of(2)) begin errors++; $display("FAIL single_pts got %h exp %h", obs_pts, slice_of(2)); end
    checks++; if (obs_start_ok !== 1'b1) begin errors++; $display("FAIL single_start pulse not exactly cycle 1"); end
    checks++; if (obs_resp_c !== 7) begin errors++; $display("FAIL single_resp_cycle got %0d exp 7", obs_resp_c); end
    checks++; if (obs_rv !== 4'b0100) begin errors++; $display("FAIL single_resp_valid got %b exp 0100", obs_rv); end
    checks++; if (obs_swap !== 1'b1 || obs_err !== 1'b0) begin errors++; $display("FAIL single_resp got swap=%b err=%b exp 1 0", obs_swap, obs_err); end
    @(posedge clk); #1;
    checks++; if (o_eval_cnt !== 32'd1 || o_swap_cnt !== 32'd1) begin errors++; $display("FAIL single_counts got %0d %0d exp 1 1", o_eval_cnt, o_swap_cnt); end
    checks++; if (o_gnt !== 4'b0000 || o_chk_pts !== slice_of(2)) begin errors++; $display("FAIL single_idle got gnt=%b pts=%h exp 0000 held", o_gnt, o_chk_pts); end
  endtask

  task automatic test_round_robin();
    int exp_order [5] = '{0, 1, 2, 3, 0};
    apply_reset();
    i_req = 4'hF;
    for (int t = 0; t < 5; t++) begin
      if (t > 0) begin @(posedge clk); #1; i_req = 4'hF; end
      do_txn(2, t[0], 1'b0, -1, '0, 40);
      checks++;
      if (obs_gnt !== (4'b0001 << exp_order[t]) || obs_rv !== obs_gnt || obs_resp_c !== 4) begin
        errors++; $display("FAIL rr_grant_%0d got gnt=%b rv=%b cyc=%0d exp engine %0d cyc 4",
                           t, obs_gnt, obs_rv, obs_resp_c, exp_order[t]);
      end
    end
    i_req = '0;
  endtask

  task automatic test_drop();
    apply_reset();
    i_req = 4'b1010;
    do_txn(4, 1'b0, 1'b0, 3, 4'b0010, 40);
    checks++; if (obs_rv !== 4'b0010 || obs_resp_c !== 6) begin errors++; $display("FAIL drop_resp got rv=%b cyc=%0d exp 0010 cyc 6", obs_rv, obs_resp_c); end
    @(posedge clk); #1;
    do_txn(1, 1'b1, 1'b0, -1, '0, 40);
    checks++; if (obs_gnt !== 4'b1000) begin errors++; $display("FAIL drop_next_gnt got %b exp 1000", obs_gnt); end
    @(posedge clk); #1;
    checks++; if (o_eval_cnt !== 32'd2 || o_swap_cnt !== 32'd1) begin errors++; $display("FAIL drop_counts got %0d %0d exp 2 1", o_eval_cnt, o_swap_cnt); end
  endtask

  task automatic test_done_early();
    apply_reset();
    i_req = 4'b0001;
    do_txn(0, 1'b1, 1'b1, -1, '0, 40);
    checks++; if (obs_resp_c !== 3 || obs_rv !== 4'b0001 || obs_swap !== 1'b1) begin
      errors++; $display("FAIL early_done got cyc=%0d rv=%b swap=%b exp cyc 3 0001 1", obs_resp_c, obs_rv, obs_swap);
    end
  endtask

  task automatic test_watchdog();
    apply_reset();
    i_req = 4'b0001;
`ifdef ARB_TIMEOUT_EN
    do_txn(0, 1'b1, 1'b0, -1, '0, 40);
    checks++; if (obs_resp_c !== 11 || obs_err !== 1'b1 || obs_swap !== 1'b0) begin
      errors++; $display("FAIL wdog_resp got cyc=%0d err=%b swap=%b exp 11 1 0", obs_resp_c, obs_err, obs_swap);
    end
    @(posedge clk); #1;
    checks++; if (o_eval_cnt !== 32'd0 || o_swap_cnt !== 32'd0) begin errors++; $display("FAIL wdog_counts got %0d %0d exp 0 0", o_eval_cnt, o_swap_cnt); end
`else
    do_txn(0, 1'b1, 1'b0, -1, '0, 1000);
    checks++; if (obs_resp_c !== -1 || o_gnt !== 4'b0001) begin
      errors++; $display("FAIL nowdog_wait got resp cyc=%0d gnt=%b exp none 0001", obs_resp_c, o_gnt);
    end
    i_chk_done = 1'b1; i_chk_res = 1'b0;
    @(posedge clk); #1;
    checks++; if (o_resp_valid !== 4'b0001 || o_resp_err !== 1'b0) begin
      errors++; $display("FAIL nowdog_release got rv=%b err=%b exp 0001 0", o_resp_valid, o_resp_err);
    end
    i_chk_done = 1'b0; i_req = '0;
`endif
  endtask

  task automatic test_random();
    int w, dly;
    logic res;
    apply_reset();
    for (int t = 0; t < 30; t++) begin
      if (t > 0) begin
        @(posedge clk); #1;
        checks++;
        if (o_eval_cnt !== m_eval || o_swap_cnt !== m_swap) begin
          errors++; $display("FAIL rand_counts_%0d got %0d %0d exp %0d %0d", t, o_eval_cnt, o_swap_cnt, m_eval, m_swap);
        end
      end
      for (int e = 0; e < N; e++) begin
        if (!i_req[e] && $urandom_range(1, 0) == 1) begin
          for (int k = 0; k < 12; k++) pts[e][k] = $urandom;
          i_req[e] = 1'b1;
        end
      end
      if (i_req == '0) begin
        w = $urandom_range(N - 1, 0);
        for (int k = 0; k < 12; k++) pts[w][k] = $urandom;
        i_req[w] = 1'b1;
      end
      pack_pts();
      w   = model_pick(i_req);
      dly = $urandom_range(6, 1);
      res = 1'($urandom_range(1, 0));
      do_txn(dly, res, 1'b0, -1, '0, 40);
      checks++;
      if (obs_gnt !== (4'b0001 << w) || obs_pts !== slice_of(w) || obs_start_ok !== 1'b1 ||
          obs_resp_c !== 2 + dly || obs_rv !== (4'b0001 << w) || obs_swap !== res || obs_err !== 1'b0) begin
        errors++; $display("FAIL rand_txn_%0d got gnt=%b cyc=%0d rv=%b swap=%b err=%b start_ok=%b exp engine %0d cyc %0d swap %b",
                           t, obs_gnt, obs_resp_c, obs_rv, obs_swap, obs_err, obs_start_ok, w, 2 + dly, res);
      end
      m_ptr  = (w + 1) % N;
      m_eval = m_eval + 1;
      m_swap = m_swap + 32'(res);
    end
    @(posedge clk); #1;
    checks++;
    if (o_eval_cnt !== m_eval || o_swap_cnt !== m_swap) begin
      errors++; $display("FAIL rand_counts_final got %0d %0d exp %0d %0d", o_eval_cnt, o_swap_cnt, m_eval, m_swap);
    end
    i_req = '0;
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int k = 0; k < 12; k++) pts[2][k] = $urandom;
    pack_pts();
    i_req = 4'b0100;
    do_txn(1, 1'b1, 1'b0, -1, '0, 40);
    @(posedge clk); #1;
    i_req = 4'b1010;
    @(posedge clk); #1;
    checks++; if (o_gnt !== 4'b1000) begin errors++; $display("FAIL arst_pre_gnt got %b exp 1000", o_gnt); end
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({o_gnt, o_chk_pts, o_chk_start, o_resp_valid, o_resp_swap, o_resp_err, o_eval_cnt, o_swap_cnt} !== '0) begin
      errors++; $display("FAIL arst_outputs gnt=%b rv=%b eval=%0d swap=%0d exp all zero",
                         o_gnt, o_resp_valid, o_eval_cnt, o_swap_cnt);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    m_ptr = 0; m_eval = 0; m_swap = 0;
    do_txn(1, 1'b0, 1'b0, -1, '0, 40);
    checks++; if (obs_gnt !== 4'b0010 || obs_rv !== 4'b0010) begin
      errors++; $display("FAIL arst_next_gnt got gnt=%b rv=%b exp 0010", obs_gnt, obs_rv);
    end
    i_req = '0;
  endtask

  initial begin
    rst = 1'b0; i_req = '0; i_req_pts = '0; i_chk_done = 1'b0; i_chk_res = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_drop();
    test_done_early();
    test_watchdog();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
